// File: rtl/vram_arbiter.sv
// VDU character RAM arbiter: video fetches take priority over Z180 CPU accesses.
// Each access holds the SRAM for RAM_CYCLES clocks; accesses are separated by at least one idle cycle.
module vram_arbiter #(
  parameter int unsigned ADDR_W     = 11,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned RAM_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_data,
  output logic              vid_valid,
  output logic              vid_ovr,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_wait,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              ram_oe,
  output logic              ram_we
);

  typedef enum logic [1:0] {IDLE, VID, CPU} state_t;

  localparam logic [1:0] CNT_LAST = 2'(RAM_CYCLES);

  state_t            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              vid_pend_q, vid_pend_d;
  logic [ADDR_W-1:0] vid_addr_q, vid_addr_d;
  logic              vid_ovr_q, vid_ovr_d;
  logic              armed_q, armed_d;
  logic [ADDR_W-1:0] cpu_addr_q, cpu_addr_d;
  logic [DATA_W-1:0] cpu_wdata_q, cpu_wdata_d;
  logic              cpu_we_q, cpu_we_d;
  logic [DATA_W-1:0] vid_data_q, vid_data_d;
  logic              vid_valid_q, vid_valid_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_din_q, ram_din_d;
  logic              ram_oe_q, ram_oe_d;
  logic              ram_we_q, ram_we_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    vid_pend_d  = vid_pend_q;
    vid_addr_d  = vid_addr_q;
    vid_ovr_d   = vid_ovr_q;
    armed_d     = armed_q;
    cpu_addr_d  = cpu_addr_q;
    cpu_wdata_d = cpu_wdata_q;
    cpu_we_d    = cpu_we_q;
    vid_data_d  = vid_data_q;
    vid_valid_d = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    cpu_ack_d   = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_din_d   = ram_din_q;
    ram_oe_d    = 1'b0;
    ram_we_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (vid_pend_q | vid_req) begin
          state_d = VID;
          cnt_d   = 2'd1;
        end else if (cpu_req & armed_q) begin
          state_d     = CPU;
          cnt_d       = 2'd1;
          cpu_addr_d  = cpu_addr;
          cpu_wdata_d = cpu_wdata;
          cpu_we_d    = cpu_we;
        end
      end
      VID: begin
        if (cnt_q == CNT_LAST) begin
          vid_data_d  = ram_dout;
          vid_valid_d = 1'b1;
          vid_pend_d  = 1'b0;
          state_d     = IDLE;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      CPU: begin
        if (cnt_q == CNT_LAST) begin
          if (!cpu_we_q) cpu_rdata_d = ram_dout;
          cpu_ack_d = 1'b1;
          // armed drops at completion (not at entry) so WAIT stays asserted for the whole access
          armed_d   = 1'b0;
          state_d   = IDLE;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // A request landing on the completing cycle stays pending for the next fetch
    if (vid_req) begin
      vid_pend_d = 1'b1;
      vid_addr_d = vid_addr;
      if (vid_pend_q) vid_ovr_d = 1'b1;
    end
    if (!cpu_req) armed_d = 1'b1;

    case (state_d)
      VID: begin
        ram_oe_d = 1'b1;
        if (state_q != VID) ram_addr_d = vid_addr_d;
      end
      CPU: begin
        ram_addr_d = cpu_addr_d;
        ram_oe_d   = ~cpu_we_d;
        ram_we_d   = cpu_we_d & (cnt_d >= 2'd2);
        if (cpu_we_d) ram_din_d = cpu_wdata_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      vid_pend_q  <= 1'b0;
      vid_addr_q  <= '0;
      vid_ovr_q   <= 1'b0;
      armed_q     <= 1'b1;
      cpu_addr_q  <= '0;
      cpu_wdata_q <= '0;
      cpu_we_q    <= 1'b0;
      vid_data_q  <= '0;
      vid_valid_q <= 1'b0;
      cpu_rdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      ram_addr_q  <= '0;
      ram_din_q   <= '0;
      ram_oe_q    <= 1'b0;
      ram_we_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      vid_pend_q  <= vid_pend_d;
      vid_addr_q  <= vid_addr_d;
      vid_ovr_q   <= vid_ovr_d;
      armed_q     <= armed_d;
      cpu_addr_q  <= cpu_addr_d;
      cpu_wdata_q <= cpu_wdata_d;
      cpu_we_q    <= cpu_we_d;
      vid_data_q  <= vid_data_d;
      vid_valid_q <= vid_valid_d;
      cpu_rdata_q <= cpu_rdata_d;
      cpu_ack_q   <= cpu_ack_d;
      ram_addr_q  <= ram_addr_d;
      ram_din_q   <= ram_din_d;
      ram_oe_q    <= ram_oe_d;
      ram_we_q    <= ram_we_d;
    end
  end

  assign vid_data  = vid_data_q;
  assign vid_valid = vid_valid_q;
  assign vid_ovr   = vid_ovr_q;
  assign cpu_rdata = cpu_rdata_q;
  assign cpu_ack   = cpu_ack_q;
  assign cpu_wait  = cpu_req & armed_q & ~cpu_ack_q;
  assign ram_addr  = ram_addr_q;
  assign ram_din   = ram_din_q;
  assign ram_oe    = ram_oe_q;
  assign ram_we    = ram_we_q;

endmodule
